// File: rtl/addsub_pkg.sv
// Shared constants and FSM state encoding for the digit-serial adder/subtractor.
// Imported by the datapath slice and the sequencing top.
package addsub_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/AddSub4Bit.sv
// One-digit add/subtract slice. In subtract mode ci_i is a borrow-in,
// so the slice computes a + ~b + ~ci and co_o is the "no borrow" carry.
module AddSub4Bit
    import addsub_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               ci_i,
    input  logic               sub_i,
    output logic [DIGIT_W-1:0] s_o,
    output logic               co_o
);

    logic [DIGIT_W-1:0] b_x;
    logic               c_x;

    assign b_x = sub_i ? ~b_i : b_i;
    assign c_x = sub_i ? ~ci_i : ci_i;

    // Single digit-wide sum with carry out
    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_x} + {{DIGIT_W{1'b0}}, c_x};

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial W-bit add/subtract: one 4-bit slice reused LSB digit first,
// with valid/ready handshakes on both sides and registered flags.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGIT_W*NIBBLES-1:0] a,
    input  logic [DIGIT_W*NIBBLES-1:0] b,
    input  logic                       cin,
    input  logic                       sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*NIBBLES-1:0] s,
    output logic                       cout,
    output logic                       ovf,
    output logic                       zero
);

    localparam int W  = DIGIT_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           sub_q, sub_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   s_q, s_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic           zero_q, zero_d;

    logic [DIGIT_W-1:0] dp_a, dp_b, dp_s;
    logic               dp_co;
    logic               nxt_c;

    assign dp_a = a_q[idx_q*DIGIT_W +: DIGIT_W];
    assign dp_b = b_q[idx_q*DIGIT_W +: DIGIT_W];

    AddSub4Bit u_dp (
        .a_i   (dp_a),
        .b_i   (dp_b),
        .ci_i  (carry_q),
        .sub_i (sub_q),
        .s_o   (dp_s),
        .co_o  (dp_co)
    );

    // Carry/borrow handed to the next digit (and final cout)
    assign nxt_c = sub_q ? ~dp_co : dp_co;

    // Next-state: accept, step one digit per cycle, hold result until taken
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_d[idx_q*DIGIT_W +: DIGIT_W] = dp_s;
                carry_d = nxt_c;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    cout_d  = nxt_c;
                    ovf_d   = (a_q[W-1] == (b_q[W-1] ^ sub_q))
                            & (s_d[W-1] != a_q[W-1]);
                    zero_d  = (s_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
